// File: rtl/inst_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_ABS = 2'd1,
    SEL_REL = 2'd2
  } pc_sel_t;

  localparam logic [8:0] HALT_INST = 9'h1FF;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch control/status bundle; master is the sequencer/ROM side, slave is inst_fetch.
interface inst_fetch_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         start;
  logic [A-1:0] start_addr;
  logic         stall;
  logic         branch;
  logic         branch_rel;
  logic [A-1:0] offset;
  logic         halt;
  logic [A-1:0] inst_address;
  logic [W-1:0] inst_out;
  logic [W-1:0] inst;
  logic [A-1:0] inst_addr;
  logic         inst_valid;
  logic         done;
  logic         pc_wrap;
  logic [15:0]  cycle_count;

  modport master (
    output start, start_addr, stall, branch, branch_rel, offset, halt, inst_out,
    input  inst_address, inst, inst_addr, inst_valid, done, pc_wrap, cycle_count
  );

  modport slave (
    input  start, start_addr, stall, branch, branch_rel, offset, halt, inst_out,
    output inst_address, inst, inst_addr, inst_valid, done, pc_wrap, cycle_count
  );
endinterface

// File: rtl/pc_next.sv
// Next-PC selection: increment, absolute target or target relative to the current instruction.
module pc_next
  import inst_pkg::*;
#(
  parameter int A = 10
) (
  input  pc_sel_t      sel,
  input  logic [A-1:0] pc,
  input  logic [A-1:0] inst_addr,
  input  logic [A-1:0] offset,
  output logic [A-1:0] next_pc,
  output logic         wrap
);

  // Relative add at width A is the same as sign-extending the offset and wrapping.
  always_comb begin
    next_pc = pc + A'(1);
    wrap    = &pc;
    case (sel)
      SEL_ABS: begin
        next_pc = offset;
        wrap    = 1'b0;
      end
      SEL_REL: begin
        next_pc = inst_addr + offset;
        wrap    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: drives the external ROM address and registers one instruction per cycle.
//   state | meaning
//   IDLE  | waiting for start, no fetches
//   RUN   | fetching; stall > halt > branch > sequential
//   HALT  | program finished, done high, state frozen
module inst_fetch
  import inst_pkg::*;
#(
  parameter int A = 10,
  parameter int W = 9
) (
  input logic        clk,
  input logic        rst_n,
  inst_fetch_if.slave bus
);

  fetch_state_t state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [W-1:0] inst_q, inst_d;
  logic [A-1:0] inst_addr_q, inst_addr_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic [15:0]  cnt_q, cnt_d;

  pc_sel_t      pc_sel;
  logic [A-1:0] next_pc;
  logic         next_wrap;
  logic         halt_cond;

  assign pc_sel    = (bus.branch && valid_q) ? (bus.branch_rel ? SEL_REL : SEL_ABS) : SEL_SEQ;
  assign halt_cond = bus.halt || (valid_q && (inst_q == W'(HALT_INST)));

  pc_next #(.A(A)) u_pc_next (
    .sel       (pc_sel),
    .pc        (pc_q),
    .inst_addr (inst_addr_q),
    .offset    (bus.offset),
    .next_pc   (next_pc),
    .wrap      (next_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      inst_addr_q <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    valid_d     = valid_q;
    wrap_d      = wrap_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          pc_d    = bus.start_addr;
          valid_d = 1'b0;
          cnt_d   = '0;
          wrap_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus.stall) begin
          // hold everything except the cycle counter
        end else if (halt_cond) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (pc_sel != SEL_SEQ) begin
          // the word at pc_q is squashed, leaving one bubble
          pc_d    = next_pc;
          valid_d = 1'b0;
        end else begin
          inst_d      = bus.inst_out;
          inst_addr_d = pc_q;
          valid_d     = 1'b1;
          pc_d        = next_pc;
          if (next_wrap) wrap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inst_address = pc_q;
  assign bus.inst         = inst_q;
  assign bus.inst_addr    = inst_addr_q;
  assign bus.inst_valid   = valid_q;
  assign bus.done         = (state_q == HALT);
  assign bus.pc_wrap      = wrap_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational ROM model.
module tb_inst_fetch;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [8:0] rom [0:1023];

  inst_fetch_if #(.A(10), .W(9)) bus ();

  inst_fetch #(.A(10), .W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.inst_out = rom[bus.inst_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.stall      = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_rel = 1'b0;
    bus.offset     = '0;
    bus.halt       = 1'b0;
  endtask

  task automatic start_at(input logic [9:0] addr);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    tick(1);
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_cmp++; if (bus.inst_address !== 10'h000) begin n_err++; $display("FAIL rst_pc: got %h want %h", bus.inst_address, 10'h000); end
    n_cmp++; if (bus.inst !== 9'h000) begin n_err++; $display("FAIL rst_inst: got %h want %h", bus.inst, 9'h000); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.cycle_count !== 16'h0000) begin n_err++; $display("FAIL rst_cnt: got %h want 0000", bus.cycle_count); end
    rst_n = 1'b1;
    bus.stall = 1'b1; bus.branch = 1'b1; bus.halt = 1'b1; bus.offset = 10'h123;
    tick(3);
    n_cmp++; if (bus.inst_address !== 10'h000) begin n_err++; $display("FAIL idle_pc: got %h want %h", bus.inst_address, 10'h000); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.cycle_count !== 16'h0000) begin n_err++; $display("FAIL idle_cnt: got %h want 0000", bus.cycle_count); end
    clear_inputs();
  endtask

  task automatic test_program();
    start_at(10'h000);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL prog_v0: got %b want 0", bus.inst_valid); end
    tick(1);
    n_cmp++; if (bus.inst !== 9'h011) begin n_err++; $display("FAIL prog_i0: got %h want 011", bus.inst); end
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL prog_v1: got %b want 1", bus.inst_valid); end
    tick(1);
    n_cmp++; if (bus.inst !== 9'h022) begin n_err++; $display("FAIL prog_i1: got %h want 022", bus.inst); end
    n_cmp++; if (bus.inst_addr !== 10'h001) begin n_err++; $display("FAIL prog_a1: got %h want 001", bus.inst_addr); end
    tick(1);
    n_cmp++; if (bus.inst !== 9'h1FF) begin n_err++; $display("FAIL prog_i2: got %h want 1ff", bus.inst); end
    n_cmp++; if (bus.cycle_count !== 16'd3) begin n_err++; $display("FAIL prog_cnt3: got %0d want 3", bus.cycle_count); end
    tick(1);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL prog_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.cycle_count !== 16'd4) begin n_err++; $display("FAIL prog_cnt4: got %0d want 4", bus.cycle_count); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL prog_vh: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_address !== 10'h003) begin n_err++; $display("FAIL prog_pch: got %h want 003", bus.inst_address); end
    bus.stall = 1'b1; bus.branch = 1'b1; bus.halt = 1'b1; bus.offset = 10'h200;
    tick(2);
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL halt_frz_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.cycle_count !== 16'd4) begin n_err++; $display("FAIL halt_frz_cnt: got %0d want 4", bus.cycle_count); end
    n_cmp++; if (bus.inst_address !== 10'h003) begin n_err++; $display("FAIL halt_frz_pc: got %h want 003", bus.inst_address); end
    clear_inputs();
  endtask

  task automatic test_branch();
    start_at(10'h003);
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h003) begin n_err++; $display("FAIL br_seq3: got %h want 003", bus.inst_addr); end
    bus.start = 1'b1; bus.start_addr = 10'h300;
    tick(1);
    bus.start = 1'b0;
    n_cmp++; if (bus.inst_address !== 10'h005) begin n_err++; $display("FAIL run_start_ign: got %h want 005", bus.inst_address); end
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h005) begin n_err++; $display("FAIL br_seq5: got %h want 005", bus.inst_addr); end
    bus.branch = 1'b1; bus.branch_rel = 1'b1; bus.offset = 10'h3FE;
    tick(1);
    bus.branch = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL br_rel_bubble: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_address !== 10'h003) begin n_err++; $display("FAIL br_rel_pc: got %h want 003", bus.inst_address); end
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h003) begin n_err++; $display("FAIL br_rel_addr: got %h want 003", bus.inst_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL br_rel_valid: got %b want 1", bus.inst_valid); end
    bus.branch = 1'b1; bus.branch_rel = 1'b0; bus.offset = 10'h050;
    tick(1);
    n_cmp++; if (bus.inst_address !== 10'h050) begin n_err++; $display("FAIL br_abs_pc: got %h want 050", bus.inst_address); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL br_abs_bubble: got %b want 0", bus.inst_valid); end
    bus.offset = 10'h100;
    tick(1);
    bus.branch = 1'b0;
    n_cmp++; if (bus.inst_addr !== 10'h050) begin n_err++; $display("FAIL br_ign_addr: got %h want 050", bus.inst_addr); end
    n_cmp++; if (bus.inst !== 9'h050) begin n_err++; $display("FAIL br_ign_inst: got %h want 050", bus.inst); end
    n_cmp++; if (bus.inst_address !== 10'h051) begin n_err++; $display("FAIL br_ign_pc: got %h want 051", bus.inst_address); end
    clear_inputs();
  endtask

  task automatic test_stall();
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ext_halt: got %b want 1", bus.done); end
    start_at(10'h020);
    tick(2);
    n_cmp++; if (bus.cycle_count !== 16'd2) begin n_err++; $display("FAIL st_cnt2: got %0d want 2", bus.cycle_count); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++; if (bus.inst_addr !== 10'h021 || bus.inst !== 9'h021 || bus.inst_address !== 10'h022 || bus.inst_valid !== 1'b1)
        begin n_err++; $display("FAIL st_hold%0d: got addr %h inst %h pc %h v %b want 021 021 022 1", i, bus.inst_addr, bus.inst, bus.inst_address, bus.inst_valid); end
    end
    n_cmp++; if (bus.cycle_count !== 16'd5) begin n_err++; $display("FAIL st_cnt5: got %0d want 5", bus.cycle_count); end
    bus.halt = 1'b1;
    tick(1);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL st_over_halt: got %b want 0", bus.done); end
    bus.stall = 1'b0; bus.halt = 1'b0;
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h022) begin n_err++; $display("FAIL st_resume: got %h want 022", bus.inst_addr); end
    n_cmp++; if (bus.cycle_count !== 16'd7) begin n_err++; $display("FAIL st_cnt7: got %0d want 7", bus.cycle_count); end
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    n_cmp++; if (bus.done !== 1'b1 || bus.inst_address !== 10'h023) begin n_err++; $display("FAIL st_halt: got done %b pc %h want 1 023", bus.done, bus.inst_address); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    start_at(10'h3FE);
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h3FE || bus.pc_wrap !== 1'b0) begin n_err++; $display("FAIL wr_f0: got addr %h wrap %b want 3fe 0", bus.inst_addr, bus.pc_wrap); end
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h3FF || bus.inst !== 9'h0FF) begin n_err++; $display("FAIL wr_f1: got addr %h inst %h want 3ff 0ff", bus.inst_addr, bus.inst); end
    n_cmp++; if (bus.inst_address !== 10'h000) begin n_err++; $display("FAIL wr_pc0: got %h want 000", bus.inst_address); end
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h000 || bus.inst !== 9'h011) begin n_err++; $display("FAIL wr_f2: got addr %h inst %h want 000 011", bus.inst_addr, bus.inst); end
    n_cmp++; if (bus.pc_wrap !== 1'b1) begin n_err++; $display("FAIL wr_flag: got %b want 1", bus.pc_wrap); end
    bus.branch = 1'b1; bus.branch_rel = 1'b1; bus.offset = 10'h3FF;
    tick(1);
    bus.branch = 1'b0;
    n_cmp++; if (bus.inst_address !== 10'h3FF) begin n_err++; $display("FAIL wr_rel_neg: got %h want 3ff", bus.inst_address); end
    tick(1);
    n_cmp++; if (bus.pc_wrap !== 1'b1 || bus.inst_address !== 10'h000) begin n_err++; $display("FAIL wr_sticky: got wrap %b pc %h want 1 000", bus.pc_wrap, bus.inst_address); end
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    start_at(10'h010);
    n_cmp++; if (bus.pc_wrap !== 1'b0 || bus.cycle_count !== 16'd0) begin n_err++; $display("FAIL wr_clear: got wrap %b cnt %0d want 0 0", bus.pc_wrap, bus.cycle_count); end
    clear_inputs();
  endtask

  task automatic test_branch_halt();
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h010) begin n_err++; $display("FAIL bh_pre: got %h want 010", bus.inst_addr); end
    bus.branch = 1'b1; bus.branch_rel = 1'b0; bus.offset = 10'h100; bus.halt = 1'b1;
    tick(1);
    clear_inputs();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL bh_done: got %b want 1", bus.done); end
    n_cmp++; if (bus.inst_address !== 10'h011) begin n_err++; $display("FAIL bh_pc: got %h want 011", bus.inst_address); end
  endtask

  task automatic test_reset_mid_run();
    start_at(10'h060);
    tick(2);
    n_cmp++; if (bus.inst_addr !== 10'h061 || bus.inst !== 9'h061) begin n_err++; $display("FAIL rm_pre: got addr %h inst %h want 061 061", bus.inst_addr, bus.inst); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.inst_address !== 10'h000 || bus.inst !== 9'h000 || bus.inst_addr !== 10'h000)
      begin n_err++; $display("FAIL rm_async: got pc %h inst %h addr %h want 000 000 000", bus.inst_address, bus.inst, bus.inst_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b0 || bus.cycle_count !== 16'd0 || bus.done !== 1'b0 || bus.pc_wrap !== 1'b0)
      begin n_err++; $display("FAIL rm_async_st: got v %b cnt %0d done %b wrap %b want 0 0 0 0", bus.inst_valid, bus.cycle_count, bus.done, bus.pc_wrap); end
    #2 rst_n = 1'b1;
    tick(3);
    n_cmp++; if (bus.inst_address !== 10'h000 || bus.inst_valid !== 1'b0 || bus.cycle_count !== 16'd0)
      begin n_err++; $display("FAIL rm_idle: got pc %h v %b cnt %0d want 000 0 0", bus.inst_address, bus.inst_valid, bus.cycle_count); end
    start_at(10'h070);
    tick(1);
    n_cmp++; if (bus.inst_addr !== 10'h070 || bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL rm_restart: got addr %h v %b want 070 1", bus.inst_addr, bus.inst_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 32'hFF);
    rom[0] = 9'h011;
    rom[1] = 9'h022;
    rom[2] = 9'h1FF;
    clear_inputs();
    test_reset();
    test_program();
    test_branch();
    test_stall();
    test_wrap();
    test_branch_halt();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
